// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding read handshake,
// buffers one instruction for decode and applies redirects with delay-slot semantics.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_allowin,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jrpc,
  input  logic [31:0] jpc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [XLEN-1:0] br_target_q, br_target_d;
  logic            br_pending_q, br_pending_d;
  logic            ds_left_q, ds_left_d;
  logic            cancel_q, cancel_d;
  logic            inst_req_d;
  logic [XLEN-1:0] inst_addr_d;
  logic            if_valid_d;
  logic [XLEN-1:0] if_pc_d, if_inst_d;

  logic            redirect_c, inflight_c, issue_c;
  logic [XLEN-1:0] target_c, issue_addr_c;

  assign redirect_c = id_allowin && (pcsource != PC_SEQ);
  assign inflight_c = (state_q != S_IDLE);
  assign issue_c    = (state_q == S_IDLE) && (!if_valid || id_allowin) && !redirect_c;

  // Redirect target mux; the sequential encoding never reaches a consumer.
  always_comb begin
    target_c = jpc;
    case (pcsource)
      PC_BR:   target_c = bpc;
      PC_JR:   target_c = jrpc;
      default: target_c = jpc;
    endcase
  end

  // Once the delay slot has been issued, the pending target is next.
  assign issue_addr_c = (br_pending_q && !ds_left_q) ? br_target_q : next_pc_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    next_pc_d    = next_pc_q;
    br_target_d  = br_target_q;
    br_pending_d = br_pending_q;
    ds_left_d    = ds_left_q;
    cancel_d     = cancel_q;
    inst_addr_d  = inst_addr;
    if_valid_d   = if_valid;
    if_pc_d      = if_pc;
    if_inst_d    = if_inst;

    case (state_q)
      S_IDLE:  if (issue_c)      state_d = S_REQ;
      S_REQ:   if (inst_addr_ok) state_d = S_WAIT;
      S_WAIT:  if (inst_data_ok) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase

    if (issue_c) begin
      inst_addr_d = issue_addr_c;
      next_pc_d   = issue_addr_c + PC_STEP;
      if (br_pending_q) begin
        if (ds_left_q) ds_left_d    = 1'b0;
        else           br_pending_d = 1'b0;
      end
    end

    if (id_allowin && if_valid)
      if_valid_d = 1'b0;

    if ((state_q == S_WAIT) && inst_data_ok) begin
      if (cancel_q) begin
        cancel_d = 1'b0;
      end else begin
        if_valid_d = 1'b1;
        if_pc_d    = inst_addr;
        if_inst_d  = inst_rdata;
      end
    end

    // Delay slot is the buffered word, else the inflight read, else the next issue.
    if (redirect_c) begin
      br_target_d  = target_c;
      br_pending_d = 1'b1;
      ds_left_d    = !(if_valid || inflight_c);
      cancel_d     = if_valid && inflight_c;
    end

    inst_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      next_pc_q    <= RESET_PC;
      br_target_q  <= '0;
      br_pending_q <= 1'b0;
      ds_left_q    <= 1'b0;
      cancel_q     <= 1'b0;
      inst_req     <= 1'b0;
      inst_addr    <= RESET_PC;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_inst      <= '0;
    end else begin
      state_q      <= state_d;
      next_pc_q    <= next_pc_d;
      br_target_q  <= br_target_d;
      br_pending_q <= br_pending_d;
      ds_left_q    <= ds_left_d;
      cancel_q     <= cancel_d;
      inst_req     <= inst_req_d;
      inst_addr    <= inst_addr_d;
      if_valid     <= if_valid_d;
      if_pc        <= if_pc_d;
      if_inst      <= if_inst_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random memory timing and
// redirects, checked against an instruction-stream model of delay-slot behaviour.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_allowin = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, jrpc = '0, jpc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .id_allowin(id_allowin), .pcsource(pcsource),
    .bpc(bpc), .jrpc(jrpc), .jpc(jpc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  int errors = 0;
  int checks = 0;

  // memory model
  int          acc_pct = 100;
  int          lat_max = 0;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  logic        force_data_ok = 1'b0;

  // instruction-stream model: 0 none, 1 delay slot next then target, 2 target next
  logic [31:0] m_seq = RESET_PC;
  logic [31:0] m_target = '0;
  int          m_pend = 0;
  int          deliveries = 0;

  int          cyc = 0;
  logic [31:0] iss_addr[$];
  int          iss_cyc[$];
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h9BC1_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [31:0] sel;
    logic [31:0] exp_pc;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    if (force_data_ok) begin
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hDEAD_BEEF;
    end else if (mem_busy) begin
      if (mem_cnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_word(mem_addr);
        mem_busy     = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (inst_req && ($urandom_range(99) < 32'(acc_pct))) begin
      inst_addr_ok = 1'b1;
      mem_addr     = inst_addr;
      mem_busy     = 1'b1;
      mem_cnt      = int'($urandom_range(32'(lat_max)));
    end
    if (id_allowin && pcsource != 2'b00) begin
      case (pcsource)
        2'b01:   sel = bpc;
        2'b10:   sel = jrpc;
        default: sel = jpc;
      endcase
      m_target = sel;
      m_pend   = if_valid ? 2 : 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (inst_req && !prev_req) begin
      iss_addr.push_back(inst_addr);
      iss_cyc.push_back(cyc);
    end
    if (inst_req && prev_req) check("addr_stable", inst_addr, prev_addr);
    if (if_valid && !prev_valid) begin
      if (m_pend == 2) begin
        exp_pc = m_target;
        m_pend = 0;
      end else begin
        exp_pc = m_seq;
        if (m_pend == 1) m_pend = 2;
      end
      check("deliver_pc", if_pc, exp_pc);
      check("deliver_inst", if_inst, mem_word(exp_pc));
      m_seq = exp_pc + 32'd4;
      deliveries++;
    end
    prev_req   = inst_req;
    prev_valid = if_valid;
    prev_addr  = inst_addr;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_inst_req", 32'(inst_req), 32'd0);
    check("rst_inst_addr", inst_addr, RESET_PC);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    id_allowin = 1'b0; pcsource = 2'b00;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; force_data_ok = 1'b0;
    mem_busy = 1'b0; m_seq = RESET_PC; m_pend = 0;
    prev_req = 1'b0; prev_valid = 1'b0; cyc = 0;
    iss_addr.delete(); iss_cyc.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      got = if_valid;
    end
    check("wait_valid_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    // reset release, zero-wait memory, decode always ready
    do_reset();
    id_allowin = 1'b1;
    step();
    check("first_req", 32'(inst_req), 32'd1);
    check("first_addr", inst_addr, 32'hBFC0_0000);
    step(); step();
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_pc", if_pc, 32'hBFC0_0000);
    check("first_inst", if_inst, 32'h2401_0001);
    repeat (6) step();
    check("issue_count", 32'(iss_addr.size()), 32'd3);
    if (iss_addr.size() >= 3) begin
      check("issue0_addr", iss_addr[0], 32'hBFC0_0000);
      check("issue1_addr", iss_addr[1], 32'hBFC0_0004);
      check("issue2_addr", iss_addr[2], 32'hBFC0_0008);
      check("issue0_cyc", 32'(iss_cyc[0]), 32'd1);
      check("issue1_cyc", 32'(iss_cyc[1]), 32'd4);
      check("issue2_cyc", 32'(iss_cyc[2]), 32'd7);
    end

    // decode stall holds the buffer and blocks new requests
    id_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_req", 32'(inst_req), 32'd0);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_pc", if_pc, 32'hBFC0_0008);
      check("stall_inst", if_inst, mem_word(32'hBFC0_0008));
    end
    id_allowin = 1'b1;
    step();
    check("resume_req", 32'(inst_req), 32'd1);
    check("resume_addr", inst_addr, 32'hBFC0_000C);
    check("resume_valid", 32'(if_valid), 32'd0);
    id_allowin = 1'b0;
    wait_valid(10);

    // branch with the delay slot sitting in the buffer
    id_allowin = 1'b1; pcsource = 2'b01; bpc = 32'hBFC0_0100;
    step();
    check("br_handoff", 32'(if_valid), 32'd0);
    check("br_no_issue", 32'(inst_req), 32'd0);
    pcsource = 2'b00;
    step();
    check("br_req", 32'(inst_req), 32'd1);
    check("br_addr", inst_addr, 32'hBFC0_0100);
    wait_valid(10);

    // jump while the delay-slot read is in WAIT
    step();
    check("j_ds_req", inst_addr, 32'hBFC0_0104);
    step();
    check("j_wait_req", 32'(inst_req), 32'd0);
    pcsource = 2'b11; jpc = 32'h8000_0000;
    step();
    check("j_ds_valid", 32'(if_valid), 32'd1);
    check("j_ds_pc", if_pc, 32'hBFC0_0104);
    pcsource = 2'b00;
    step();
    check("j_req", 32'(inst_req), 32'd1);
    check("j_addr", inst_addr, 32'h8000_0000);
    wait_valid(10);

    // jump-register with nothing buffered or inflight, then reset mid-WAIT
    do_reset();
    id_allowin = 1'b1; pcsource = 2'b10; jrpc = 32'h8000_1000;
    step();
    check("jr_no_issue", 32'(inst_req), 32'd0);
    pcsource = 2'b00;
    step();
    check("jr_ds_addr", inst_addr, RESET_PC);
    wait_valid(10);
    step();
    check("jr_req", 32'(inst_req), 32'd1);
    check("jr_addr", inst_addr, 32'h8000_1000);
    step();
    do_reset();
    force_data_ok = 1'b1;
    step();
    force_data_ok = 1'b0;
    check("stray_valid", 32'(if_valid), 32'd0);
    check("stray_req", 32'(inst_req), 32'd1);
    check("stray_addr", inst_addr, RESET_PC);

    // random memory timing, decode readiness and redirects
    acc_pct = 50;
    lat_max = 2;
    deliveries = 0;
    for (int i = 0; i < 4000; i++) begin
      id_allowin = ($urandom_range(9) < 7);
      bpc  = $urandom() & 32'hFFFF_FFFC;
      jrpc = $urandom() & 32'hFFFF_FFFC;
      jpc  = $urandom() & 32'hFFFF_FFFC;
      if (m_pend == 0 && $urandom_range(7) == 0) pcsource = 2'($urandom_range(3, 1));
      else pcsource = 2'b00;
      step();
    end
    check("random_progress", 32'(deliveries > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly upstream of the decode stage. It owns the PC register and issues instruction reads over a request/accept/response handshake, keeping at most one read outstanding. It buffers one fetched instruction for decode and applies decode's branch/jump redirects with MIPS delay-slot semantics.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

- clk  in  1  pipeline clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_allowin  in  1  decode accepts the buffered instruction this cycle. A control-transfer instruction also leaves decode in this cycle.
- pcsource  in  2  redirect select, sampled only when id_allowin=1: 00 sequential (no redirect), 01 bpc, 10 jrpc, 11 jpc.
- bpc  in  32  branch target.
- jrpc  in  32  jump-register target.
- jpc  in  32  jump target.
- inst_req  out  1  read request.
- inst_addr  out  32  read address; held stable while inst_req=1.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data valid; arrives at least 1 cycle after inst_addr_ok.
- inst_rdata  in  32  read data.
- if_valid  out  1  buffered instruction valid to decode.
- if_pc  out  32  PC of buffered instruction.
- if_inst  out  32  buffered instruction word.

## Operation
- FSM with states IDLE, REQ (inst_req=1) and WAIT (accepted, awaiting data).
- issue = IDLE && (!if_valid || id_allowin) && !redirect, where redirect = id_allowin && pcsource!=00.
- IDLE→REQ on issue: inst_addr latches the selected address. REQ→WAIT on inst_addr_ok. WAIT→IDLE on inst_data_ok.
- inflight = state is REQ or WAIT. A request that has not yet been accepted cannot be withdrawn.
- Address selection at issue:
  - br_pending && !ds_left: use br_target, then clear br_pending.
  - br_pending && ds_left: use next_pc (this is the delay slot), then clear ds_left.
  - Otherwise: use next_pc.
  - In every case next_pc ← issued address + 4, modulo 2^32.
- Redirect event: br_target ← selected target, br_pending ← 1.
  - ds_left ← !(if_valid || inflight). The delay slot is the first of: the buffered instruction, the inflight read, the next issue.
  - If if_valid && inflight, the inflight read lies past the delay slot: cancel ← 1.
  - A redirect while br_pending=1 overwrites br_target and recomputes ds_left/cancel.
- Data return in WAIT with inst_data_ok:
  - cancel=1: discard the data, clear cancel.
  - cancel=0: if_valid←1, if_pc←inst_addr, if_inst←inst_rdata.
- Handoff: id_allowin && if_valid clears if_valid. This never collides with a load, because issue requires the buffer to be free.
- inst_data_ok outside WAIT and inst_addr_ok outside REQ are ignored.

## Timing
- Reset values:
  - inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0.
  - next_pc=RESET_PC; br_pending, ds_left and cancel all 0; state IDLE.
- First rising edge after reset deasserts: inst_req=1, inst_addr=RESET_PC.
- Minimum fetch latency is 3 edges: issue, accept, data. if_valid rises on the edge that samples inst_data_ok.
- Peak throughput is one instruction per 3 cycles with zero-wait memory.
- Issue is suppressed in the redirect cycle. The target is requested no earlier than the following edge.
- Reset mid-REQ/WAIT aborts immediately with all outputs at reset values. A stray inst_data_ok after reset is ignored, because the state is IDLE.
- if_pc/if_inst hold their values while if_valid=1 and id_allowin=0.

## Test plan
- Reset release with 1-cycle accept and 1-cycle data, inst_rdata=0x24010001 → cycle 1 inst_addr=0xBFC00000. On the data edge: if_valid=1, if_pc=0xBFC00000, if_inst=0x24010001.
- id_allowin held 1 with zero-wait memory → issued addresses 0xBFC00000, 0xBFC00004, 0xBFC00008, in that order, 3 cycles apart.
- id_allowin=0 for 5 cycles with if_valid=1 → no new inst_req, outputs stable. When id_allowin=1, the request for the next PC issues on the next edge.
- if_valid=1 (pc 0xBFC00004), IDLE, pcsource=01, bpc=0xBFC00100 → next issued address is 0xBFC00100, and the buffered 0xBFC00004 is delivered as the delay slot.
- if_valid=1 with a read for 0xBFC00008 in WAIT, pcsource=11, jpc=0x80000000 → the 0xBFC00008 data is discarded and if_valid stays 0. The next issue is 0x80000000.
- Nothing buffered or inflight, pcsource=10, jrpc=0x80001000, next_pc=0xBFC00010 → issues 0xBFC00010 then 0x80001000. Then assert reset during WAIT → if_valid=0, inst_req=0, and a following stray inst_data_ok is ignored.
